alu_share_arbiter: RTL and testbench

- Shares the single-cycle ALU between two requesters, e.g. the main execute path and a branch/address helper.
- Arbitrates requests, registers the operands that drive the ALU, and captures the result and flags one cycle later.
- Returns a tagged response over a valid/ready handshake.
- Sits between the requesters and the ALU instance; the ALU itself stays combinational and unmodified.

---
 rtl/alu_share_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one combinational ALU and returns a tagged, registered response.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,

  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [3:0]        alu_flags,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]    rsp_result_q, rsp_result_d;
  logic [3:0]          rsp_flags_q, rsp_flags_d;
  logic                rsp_err_q, rsp_err_d;
`ifdef ALU_ARB_RR_EN
  logic                rr_ptr_q, rr_ptr_d;
`endif

  logic grant_any;
  logic grant_id;
  logic ctrl_legal;

  // Grant selection: a lone requester always wins; a tie goes to rr_ptr or to requester 0.
  always_comb begin
    grant_any = req0_valid | req1_valid;
`ifdef ALU_ARB_RR_EN
    grant_id  = (req0_valid && req1_valid) ? rr_ptr_q : !req0_valid;
`else
    grant_id  = !req0_valid;
`endif
    req0_ready = (state_q == IDLE) && grant_any && !grant_id;
    req1_ready = (state_q == IDLE) && grant_any &&  grant_id;
  end

  always_comb begin
    ctrl_legal = 1'b0;
    case (alu_ctrl_q)
      CTRL_W'(0), CTRL_W'(1), CTRL_W'(2), CTRL_W'(3), CTRL_W'(5): ctrl_legal = 1'b1;
      default: ctrl_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
`ifdef ALU_ARB_RR_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          alu_a_d    = grant_id ? req1_a    : req0_a;
          alu_b_d    = grant_id ? req1_b    : req0_b;
          alu_ctrl_d = grant_id ? req1_ctrl : req0_ctrl;
          rsp_id_d   = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        // Illegal codes still drive the ALU, but its output is masked here.
        rsp_result_d = ctrl_legal ? alu_result : '0;
        rsp_flags_d  = ctrl_legal ? alu_flags  : 4'b0000;
        rsp_err_d    = !ctrl_legal;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef ALU_ARB_RR_EN
          rr_ptr_d    = !rsp_id_q;
`endif
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
      rsp_err_q    <= 1'b0;
`ifdef ALU_ARB_RR_EN
      rr_ptr_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
`ifdef ALU_ARB_RR_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a stub ALU, a transaction-level reference model checked every
// cycle, and directed scenarios with hand-computed results.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic [3:0]  alu_flags;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Returns {flags[3:0], result[31:0]} with flags = {OverFlow, Carry, Zero, Negative}.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    logic [31:0] r;
    logic        v, cy;
    v = 1'b0; cy = 1'b0;
    case (c)
      3'b000: begin {cy, r} = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: begin r = a - b; cy = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = a ^ b;
    endcase
    return {v, cy, (r == 32'd0), r[31], r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

  // Reference model: one transaction at a time, advanced on each rising edge.
  int          m_phase = 0;
  bit          m_live = 1'b0;
  bit          m_rst_last = 1'b0;
  bit          m_valid, m_id, m_err;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0]  m_ctrl;
  logic [3:0]  m_flags;
`ifdef ALU_ARB_RR_EN
  bit          m_rr;
`endif

  function automatic int grant_of(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return m_rr ? 1 : 0;
`else
      return 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    logic [35:0] fr;
    if (rst) begin
      m_live = 1'b1; m_rst_last = 1'b1; m_phase = 0;
      m_a = '0; m_b = '0; m_ctrl = '0; m_id = 1'b0; m_valid = 1'b0;
      m_res = '0; m_flags = '0; m_err = 1'b0;
`ifdef ALU_ARB_RR_EN
      m_rr = 1'b0;
`endif
    end else begin
      m_rst_last = 1'b0;
      if (m_phase == 0) begin
        g = grant_of(req0_valid, req1_valid);
        if (g == 0) begin m_a = req0_a; m_b = req0_b; m_ctrl = req0_ctrl; m_id = 1'b0; m_phase = 1; end
        if (g == 1) begin m_a = req1_a; m_b = req1_b; m_ctrl = req1_ctrl; m_id = 1'b1; m_phase = 1; end
      end else if (m_phase == 1) begin
        fr = alu_model(m_a, m_b, m_ctrl);
        if (m_ctrl inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101}) begin
          m_res = fr[31:0]; m_flags = fr[35:32]; m_err = 1'b0;
        end else begin
          m_res = '0; m_flags = '0; m_err = 1'b1;
        end
        m_valid = 1'b1; m_phase = 2;
      end else if (rsp_ready) begin
        m_valid = 1'b0; m_phase = 0;
`ifdef ALU_ARB_RR_EN
        m_rr = !m_id;
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    int g;
    if (m_live) begin
      g = grant_of(req0_valid, req1_valid);
      checkOutput("m_req0_ready", 32'(req0_ready), 32'(m_phase == 0 && g == 0));
      checkOutput("m_req1_ready", 32'(req1_ready), 32'(m_phase == 0 && g == 1));
      checkOutput("m_alu_a", alu_a, m_a);
      checkOutput("m_alu_b", alu_b, m_b);
      checkOutput("m_alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      checkOutput("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid || m_rst_last) begin
        checkOutput("m_rsp_id", 32'(rsp_id), 32'(m_id));
        checkOutput("m_rsp_result", rsp_result, m_res);
        checkOutput("m_rsp_flags", 32'(rsp_flags), 32'(m_flags));
        checkOutput("m_rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                               input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                               input logic rdy);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
    rsp_ready  = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRsp(input string name, input logic id, input logic [31:0] res, input logic [3:0] fl, input logic err);
    checkOutput({name, "_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({name, "_id"}, 32'(rsp_id), 32'(id));
    checkOutput({name, "_result"}, rsp_result, res);
    checkOutput({name, "_flags"}, 32'(rsp_flags), 32'(fl));
    checkOutput({name, "_err"}, 32'(rsp_err), 32'(err));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    checkOutput("rst_valid", 32'(rsp_valid), 0);
    checkOutput("rst_ready0", 32'(req0_ready), 0);
    checkOutput("rst_ready1", 32'(req1_ready), 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_ctrl", 32'(alu_ctrl), 0);
    checkOutput("rst_result", rsp_result, 0);
    checkOutput("rst_flags", 32'(rsp_flags), 0);

    // Single ADD from requester 0.
    applyStimulus(1, 32'h5, 32'h3, 3'b000, 0, 0, 0, 0, 1);
    #1;
    checkOutput("add_ready0", 32'(req0_ready), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("add_exec_novalid", 32'(rsp_valid), 0);
    step();
    checkRsp("add", 0, 32'h8, 4'b0000, 0);
    step();
    checkOutput("add_done", 32'(rsp_valid), 0);

    // Tie from reset, both requesters held.
    rst = 1'b1; step(); rst = 1'b0;
    applyStimulus(1, 32'h7, 32'h2, 3'b001, 1, 32'hF0F0F0F0, 32'h0F0F0F0F, 3'b010, 1);
    #1;
    checkOutput("tie_ready0", 32'(req0_ready), 1);
    checkOutput("tie_ready1", 32'(req1_ready), 0);
    step(); step();
    checkRsp("tie_first", 0, 32'h5, 4'b0000, 0);
    step(); step(); step();
`ifdef ALU_ARB_RR_EN
    checkRsp("tie_second", 1, 32'h0, 4'b0010, 0);
`else
    checkRsp("tie_second", 0, 32'h5, 4'b0000, 0);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();

    // Signed overflow from requester 1.
    applyStimulus(0, 0, 0, 0, 1, 32'h7FFFFFFF, 32'h1, 3'b000, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    checkRsp("ovf", 1, 32'h80000000, 4'b1001, 0);
    step();

    // SLT with a stalled consumer while both requesters wait.
    applyStimulus(1, 32'hFFFFFFFE, 32'hFFFFFFFF, 3'b101, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 32'h1, 32'h1, 3'b000, 1, 32'h1, 32'h2, 3'b011, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      checkRsp("slt_hold", 0, 32'h1, 4'b0000, 0);
      checkOutput("slt_ready0", 32'(req0_ready), 0);
      checkOutput("slt_ready1", 32'(req1_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    checkOutput("slt_released", 32'(rsp_valid), 0);
    checkOutput("slt_idle_grant", 32'(req0_ready | req1_ready), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();

    // Illegal control code.
    applyStimulus(1, 32'h3, 32'h4, 3'b111, 0, 0, 0, 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    checkRsp("illegal", 0, 32'h0, 4'b0000, 1);
    step();

    // Reset while in EXEC, then a normal transaction.
    applyStimulus(1, 32'd10, 32'd20, 3'b000, 0, 0, 0, 0, 1);
    step();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    rst = 1'b0;
    checkOutput("mid_rst_valid", 32'(rsp_valid), 0);
    checkOutput("mid_rst_alu_a", alu_a, 0);
    checkOutput("mid_rst_alu_b", alu_b, 0);
    checkOutput("mid_rst_err", 32'(rsp_err), 0);
    step();
    checkOutput("mid_rst_still", 32'(rsp_valid), 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h2, 32'h2, 3'b000, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    checkRsp("after_rst", 1, 32'h4, 4'b0000, 0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
